// File: rtl/eth_tx_frame_arbiter_pkg.sv
// rtl/eth_tx_frame_arbiter_pkg.sv - EthernetBus package: MAC tx bus struct, arbiter state enum, widths
package EthernetBus;

  localparam int LEN_W = 11;
  localparam int GAP_W = 4;

  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [31:0] data;
    logic [2:0]  bytes_valid;
  } EthernetTxBus;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } eth_tx_arb_state_t;

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_select.sv
// rtl/eth_tx_frame_arbiter_rr_select.sv - combinational round-robin pick starting after last grant
module eth_tx_rr_select #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant,
  output logic                         valid
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W:0] cand;

  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant = cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - round-robin frame arbiter to MAC tx bus; ETH_TX_ARB_STATS_EN adds per-port counters
module eth_tx_frame_arbiter
  import EthernetBus::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                         tx_clk,
  input  logic                         tx_rst,
  input  logic                         link_up,
  input  logic                         tx_ready,
  output EthernetTxBus                 tx_bus,
  input  logic [NUM_PORTS-1:0]         port_frame_avail,
  input  logic [NUM_PORTS*11-1:0]      port_frame_len,
  output logic [NUM_PORTS-1:0]         port_hdr_rd_en,
  output logic [NUM_PORTS-1:0]         port_data_rd_en,
  input  logic [NUM_PORTS*8-1:0]       port_data,
  output logic [$clog2(NUM_PORTS)-1:0] active_port,
  output logic                         busy,
  output logic [NUM_PORTS*32-1:0]      frames_sent,
  output logic [NUM_PORTS*32-1:0]      frames_dropped
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  eth_tx_arb_state_t state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  sel;
  logic              sel_valid;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  count_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              start_q;
  logic              dv_q;
  logic              grant_now;
  logic              send_now;
  logic [LEN_W-1:0]  len_arr  [NUM_PORTS];
  logic [7:0]        byte_arr [NUM_PORTS];

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_unpack
    assign len_arr[gp]  = port_frame_len[gp*LEN_W +: LEN_W];
    assign byte_arr[gp] = port_data[gp*8 +: 8];
  end

  eth_tx_rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req        (port_frame_avail),
    .last_grant (last_grant),
    .grant      (sel),
    .valid      (sel_valid)
  );

  // Pops are gated by reset and link so an abort or reset stops the FIFOs in the same cycle.
  assign grant_now = !tx_rst && (state == IDLE) && tx_ready && link_up && sel_valid;
  assign send_now  = !tx_rst && (state == SEND) && link_up;
  assign count_nxt = count + 11'd1;
  assign busy      = (state != IDLE);

  always_comb begin
    port_hdr_rd_en  = '0;
    port_data_rd_en = '0;
    if (grant_now) port_hdr_rd_en[sel] = 1'b1;
    if (send_now)  port_data_rd_en[active_port] = 1'b1;
  end

  always_comb begin
    tx_bus             = '0;
    tx_bus.start       = start_q;
    tx_bus.data_valid  = dv_q;
    tx_bus.data        = dv_q ? {24'd0, byte_arr[active_port]} : 32'd0;
    tx_bus.bytes_valid = 3'd1;
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_PORTS-1);
      active_port <= '0;
      len_q       <= '0;
      count       <= '0;
      gap_cnt     <= '0;
      start_q     <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      start_q <= send_now && (count == '0);
      dv_q    <= send_now;
      case (state)
        IDLE: begin
          if (grant_now) begin
            last_grant  <= sel;
            active_port <= sel;
            len_q       <= len_arr[sel];
            count       <= '0;
            if (len_arr[sel] != '0) state <= SEND;
          end
        end
        SEND: begin
          if (!link_up) begin
            state <= IDLE;
          end else begin
            count <= count_nxt;
            if (count_nxt == len_q) begin
              gap_cnt <= '0;
              state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          // Entered on the last data_valid cycle, so GAP_CYCLES further cycles follow it.
          if (!link_up || gap_cnt == GAP_W'(GAP_CYCLES)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_ARB_STATS_EN
  logic [31:0] sent_cnt [NUM_PORTS];
  logic [31:0] drop_cnt [NUM_PORTS];
  logic        frame_done;
  logic        frame_abort;
  logic        frame_zero;

  assign frame_done  = send_now && (count_nxt == len_q);
  assign frame_abort = !tx_rst && (state == SEND) && !link_up;
  assign frame_zero  = grant_now && (len_arr[sel] == '0);

  always_ff @(posedge tx_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (tx_rst) begin
        sent_cnt[p] <= '0;
        drop_cnt[p] <= '0;
      end else begin
        if (frame_done && active_port == IDX_W'(p)) sent_cnt[p] <= sent_cnt[p] + 32'd1;
        if ((frame_abort && active_port == IDX_W'(p)) || (frame_zero && sel == IDX_W'(p)))
          drop_cnt[p] <= drop_cnt[p] + 32'd1;
      end
    end
  end

  for (genvar gs = 0; gs < NUM_PORTS; gs++) begin : g_stats
    assign frames_sent[gs*32 +: 32]    = sent_cnt[gs];
    assign frames_dropped[gs*32 +: 32] = drop_cnt[gs];
  end
`else
  assign frames_sent    = '0;
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - scoreboard bench for eth_tx_frame_arbiter with modelled header/data FIFOs
module tb_eth_tx_frame_arbiter;
  import EthernetBus::*;

  localparam int NP    = 2;
  localparam int GAP_N = 2;
  localparam int QD    = 256;

  logic                  tx_clk = 1'b0;
  logic                  tx_rst = 1'b1;
  logic                  link_up = 1'b1;
  logic                  tx_ready = 1'b0;
  EthernetTxBus          tx_bus;
  logic [NP-1:0]         avail = '0;
  logic [NP*11-1:0]      flen = '0;
  logic [NP-1:0]         hdr_en;
  logic [NP-1:0]         data_en;
  logic [NP*8-1:0]       pdata = '0;
  logic [$clog2(NP)-1:0] active_port;
  logic                  busy;
  logic [NP*32-1:0]      frames_sent;
  logic [NP*32-1:0]      frames_dropped;

  eth_tx_frame_arbiter #(.NUM_PORTS(NP), .GAP_CYCLES(GAP_N)) dut (
    .tx_clk           (tx_clk),
    .tx_rst           (tx_rst),
    .link_up          (link_up),
    .tx_ready         (tx_ready),
    .tx_bus           (tx_bus),
    .port_frame_avail (avail),
    .port_frame_len   (flen),
    .port_hdr_rd_en   (hdr_en),
    .port_data_rd_en  (data_en),
    .port_data        (pdata),
    .active_port      (active_port),
    .busy             (busy),
    .frames_sent      (frames_sent),
    .frames_dropped   (frames_dropped)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    int port;
    int id;
    int len;
  } frame_t;

  // Source model: per-port header ring (lengths) and per-frame byte pattern.
  int lbuf [NP][QD];
  int lhead [NP];
  int ltail [NP];
  int cur_id [NP];
  int cur_idx [NP];
  logic [NP-1:0] smp_hdr = '0;
  logic [NP-1:0] smp_data = '0;
  bit rnd_ready = 0;

  // Scoreboard state
  frame_t exp_q[$];
  frame_t cur;
  bit  in_frame = 0;
  int  rx_idx = 0;
  int  cyc = 0;
  int  m_last = NP - 1;
  bit  prev_rst = 0;
  bit  end_valid = 0;
  int  end_cyc = 0;
  int  busy_hi_cyc = -1;
  int  busy_lo_cyc = -1;
  bit  abort_chk = 0;
  int  exp_sent [NP];
  int  exp_drop [NP];
  int  g;
  int  gl;
  int  n_vec = 0;
  int  n_bad = 0;

  function automatic logic [7:0] fbyte(int p, int id, int i);
    int v;
    v = p * 97 + id * 31 + i * 7 + (i >> 4);
    return 8'(v) ^ 8'h5a;
  endfunction

  function automatic int rr_pick(int last, logic [NP-1:0] av);
    for (int i = 1; i <= NP; i++) begin
      if (av[(last + i) % NP]) return (last + i) % NP;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < NP; p++) begin
      avail[p] = (lhead[p] != ltail[p]);
      flen[p*11 +: 11] = avail[p] ? 11'(lbuf[p][lhead[p] % QD]) : 11'd0;
    end
  endtask

  task automatic push_frame(int p, int len);
    lbuf[p][ltail[p] % QD] = len;
    ltail[p]++;
    drive_src();
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge tx_clk);
      #2;
    end
  endtask

  function automatic bit drained();
    bit e;
    e = 1;
    for (int p = 0; p < NP; p++) if (lhead[p] != ltail[p]) e = 0;
    return e && (exp_q.size() == 0) && !in_frame && !busy;
  endfunction

  task automatic wait_idle(string name, int budget);
    bit done;
    done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      step(1);
      done = drained();
    end
    chk(name, done, 1);
    step(2);
  endtask

  // Sources apply pops seen in the previous cycle just after the edge.
  initial forever begin
    @(posedge tx_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (smp_hdr[p]) begin
        cur_id[p]  = lhead[p];
        cur_idx[p] = 0;
        lhead[p]++;
      end
      if (smp_data[p]) begin
        pdata[p*8 +: 8] = fbyte(p, cur_id[p], cur_idx[p]);
        cur_idx[p]++;
      end else begin
        pdata[p*8 +: 8] = 8'($urandom);
      end
    end
    drive_src();
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard
  always @(negedge tx_clk) begin
    cyc++;
    smp_hdr  = hdr_en;
    smp_data = data_en;
    if (tx_rst) begin
      chk("rst_rd_en", {hdr_en, data_en}, 0);
      if (prev_rst) begin
        chk("rst_bus", {tx_bus.start, tx_bus.data_valid, tx_bus.data}, 0);
        chk("rst_port_busy", {active_port, busy}, 0);
      end
      exp_q.delete();
      in_frame = 0;
      m_last = NP - 1;
      end_valid = 0;
      abort_chk = 0;
      busy_hi_cyc = -1;
      busy_lo_cyc = -1;
      for (int p = 0; p < NP; p++) begin
        exp_sent[p] = 0;
        exp_drop[p] = 0;
      end
      prev_rst = 1;
    end else begin
      prev_rst = 0;
      if (abort_chk) begin
        abort_chk = 0;
        chk("abort_dv_low", tx_bus.data_valid, 0);
        chk("abort_idle", busy, 0);
        if (in_frame) exp_drop[cur.port]++;
        in_frame = 0;
        end_valid = 0;
      end
      if ((hdr_en | data_en) != 0) chk("rd_en_onehot", $countones({hdr_en, data_en}), 1);
      if (!link_up) chk("link_down_no_rd_en", {hdr_en, data_en}, 0);
      if (hdr_en != 0) begin
        g = rr_pick(m_last, avail);
        chk("grant_port", hdr_en, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("grant_cond", {tx_ready, link_up, busy}, 3'b110);
        if (g >= 0) begin
          gl = int'(flen[g*11 +: 11]);
          m_last = g;
          if (gl == 0) exp_drop[g]++;
          else exp_q.push_back('{g, lhead[g], gl});
        end
      end
      if (data_en != 0) chk("data_rd_port", data_en, 64'd1 << m_last);
      if (cyc == busy_hi_cyc) chk("busy_in_gap", busy, 1);
      if (cyc == busy_lo_cyc) chk("busy_low_after_gap", busy, 0);
      if (tx_bus.start) begin
        chk("start_with_dv", tx_bus.data_valid, 1);
        chk("start_expected", (exp_q.size() > 0) && !in_frame, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          in_frame = 1;
          rx_idx = 0;
          if (end_valid) chk("gap_cycles", (cyc - end_cyc - 1) >= GAP_N, 1);
          end_valid = 0;
        end
      end
      if (tx_bus.data_valid) begin
        chk("dv_in_frame", in_frame, 1);
        if (in_frame) begin
          chk("data_byte", tx_bus.data, {24'd0, fbyte(cur.port, cur.id, rx_idx)});
          chk("bytes_valid", tx_bus.bytes_valid, 1);
          rx_idx++;
          if (rx_idx == cur.len) begin
            in_frame = 0;
            exp_sent[cur.port]++;
            end_valid = 1;
            end_cyc = cyc;
            busy_hi_cyc = cyc + GAP_N;
            busy_lo_cyc = cyc + GAP_N + 1;
          end
        end
      end
      if (!link_up && in_frame) abort_chk = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int p;
    int l;
    // Reset with a frame already waiting: no pop may happen while reset is held.
    tx_ready = 1;
    push_frame(0, 4);
    step(3);
    tx_rst = 0;
    wait_idle("p0_len4_done", 200);

    push_frame(1, 0);
    wait_idle("p1_len0_done", 50);

    for (int i = 0; i < 4; i++) begin
      push_frame(0, 3);
      push_frame(1, 3);
    end
    wait_idle("alternate_len3_done", 400);

    push_frame(1, 2047);
    push_frame(0, 1);
    wait_idle("len2047_done", 3000);

    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, NP - 1);
      case ($urandom_range(0, 9))
        0:       l = 0;
        1:       l = 1;
        default: l = $urandom_range(2, 24);
      endcase
      push_frame(p, l);
      step($urandom_range(0, 8));
    end
    wait_idle("random_done", 6000);
    rnd_ready = 0;
    step(1);
    tx_ready = 1;

    // Link loss part way through a 60-byte frame.
    push_frame(0, 60);
    push_frame(1, 5);
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      step(1);
      ok = in_frame && (cur.port == 0) && (rx_idx >= 10);
    end
    chk("link_drop_reached", ok, 1);
    link_up = 0;
    tx_ready = 0;
    step(6);
    link_up = 1;
    step(3);
    tx_ready = 1;
    wait_idle("after_link_drop_done", 500);

    // Reset part way through a frame; port 0 must win first afterwards.
    push_frame(0, 50);
    push_frame(1, 4);
    ok = 0;
    for (int n = 0; n < 500 && !ok; n++) begin
      step(1);
      ok = in_frame && (cur.port == 0) && (rx_idx >= 10);
    end
    chk("reset_point_reached", ok, 1);
    push_frame(0, 6);
    tx_rst = 1;
    step(2);
    tx_rst = 0;
    wait_idle("after_reset_done", 500);

    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef ETH_TX_ARB_STATS_EN
    for (int q = 0; q < NP; q++) begin
      chk("frames_sent", frames_sent[q*32 +: 32], exp_sent[q]);
      chk("frames_dropped", frames_dropped[q*32 +: 32], exp_drop[q]);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

Interface
- REQ-001 SHALL have parameter NUM_PORTS, default 2, number of frame sources (2..8).
- REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum idle cycles between frames on tx_bus (0..15).
- REQ-003 SHALL have port tx_clk  input  1  sole clock; all logic on its rising edge.
- REQ-004 SHALL have port tx_rst  input  1  reset, synchronous, active-high.
- REQ-005 SHALL have port link_up  input  1  MAC link status, tx_clk domain.
- REQ-006 SHALL have port tx_ready  input  1  MAC can accept a new frame.
- REQ-007 SHALL have port tx_bus  output  EthernetTxBus  frame stream to MAC; data[31:8]=0, bytes_valid=1.
- REQ-008 SHALL have port port_frame_avail  input  NUM_PORTS  header FIFO non-empty, per port.
- REQ-009 SHALL have port port_frame_len  input  NUM_PORTS*11  show-ahead frame length in bytes, valid while avail.
- REQ-010 SHALL have port port_hdr_rd_en  output  NUM_PORTS  one-cycle header pop.
- REQ-011 SHALL have port port_data_rd_en  output  NUM_PORTS  byte pop, one per cycle.
- REQ-012 SHALL have port port_data  input  NUM_PORTS*8  byte, valid one cycle after matching data_rd_en.
- REQ-013 SHALL have port active_port  output  $clog2(NUM_PORTS)  port currently granted.
- REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
- REQ-015 SHALL implement states IDLE, SEND, GAP.
- REQ-016 IDLE SHALL grant when tx_ready && link_up && any avail: round-robin search starting at last_grant+1 mod NUM_PORTS; latch len, pulse port_hdr_rd_en[sel] the same cycle, set active_port=sel.
- REQ-017 On grant with len==0 SHALL pop the header only, assert no start/data_valid, stay IDLE, advance last_grant.
- REQ-018 On grant with len>0 SHALL enter SEND with count=0.
- REQ-019 SEND SHALL assert port_data_rd_en[active_port] every cycle, count+=1, until count==len, then enter GAP (or IDLE when GAP_CYCLES==0).
- REQ-020 tx_bus.start SHALL pulse one cycle, registered, coincident with first data_rd_en cycle +1 of grant; tx_bus.data_valid SHALL equal data_rd_en delayed one cycle; tx_bus.data[7:0] SHALL be port_data[active_port] while data_valid.
- REQ-021 Exactly len data_valid cycles SHALL occur per frame; no more than one port_*_rd_en bit high per cycle.
- REQ-022 GAP SHALL wait GAP_CYCLES cycles after the last data_valid, then IDLE.
- REQ-023 link_up falling in SEND/GAP SHALL abort: IDLE next cycle, no further rd_en, data_valid low after the in-flight byte.
- REQ-024 len arithmetic SHALL be 11-bit unsigned; len 2047 SHALL be sent in full without wrap.
- REQ-025 tx_ready SHALL be sampled only in IDLE; deassertion mid-frame SHALL be ignored.

Reset
- REQ-026 tx_rst SHALL force IDLE, last_grant=NUM_PORTS-1 (port 0 first), all rd_en=0, tx_bus.start=0, data_valid=0, data=0, active_port=0, busy=0, counters=0.
- REQ-027 tx_rst mid-frame SHALL take effect the next edge with no further pops.

Configuration
- REQ-028 With ETH_TX_ARB_STATS_EN defined SHALL add outputs frames_sent and frames_dropped, NUM_PORTS*32 each, per-port wrapping counters incremented at frame completion (REQ-019) and zero-length/aborted frames respectively.
- REQ-029 Without ETH_TX_ARB_STATS_EN these outputs SHALL exist tied to 0 and no counter logic SHALL be synthesized.

Structure
- REQ-030 EthernetTxBus SHALL come from package EthernetBus; state enum eth_tx_arb_state_t SHALL be added there.
- REQ-031 Round-robin priority search SHALL be sub-module eth_tx_rr_select (combinational, request vector + last grant -> grant index + valid).

Verification
- REQ-032 Port0 len=4 avail, tx_ready=1 -> hdr_rd_en[0] once, start once, 4 data_valid bytes matching source, busy low GAP_CYCLES+1 after.
- REQ-033 Both ports avail len=3 continuously -> grants alternate 0,1,0,1; gap >=2 idle cycles between frames.
- REQ-034 Port1 len=0 -> hdr_rd_en[1] pulse, no start, frames_dropped[1]=1 (stats build).
- REQ-035 link_up drop after 10 of 60 bytes -> rd_en stops next cycle, IDLE, no start until link_up and tx_ready return.
- REQ-036 tx_rst asserted mid-frame -> all outputs reset values next cycle; port 0 wins first grant after release.
